if_id_skid: RTL and testbench

Parametrised IF/ID pipeline stage with a valid/ready handshake, an optional 2-entry skid buffer, and a synchronous flush that injects a NOP bubble. It sits between instruction fetch and decode. It replaces the single-register hold/flush stage: stall (downstream not ready) and flush (discard) are now distinct. No beat is lost or duplicated under back-pressure.

---
 rtl/if_id_skid.sv | 121 ++++++++++++
 tb/tb_if_id_skid.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
// if_id_skid -- IF/ID pipeline stage with valid/ready handshake, optional
// 2-entry skid buffer and a synchronous flush that injects a NOP bubble.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   inst_i           fetched instruction
//   inst_addr_i      address of inst_i
//   valid_i          fetch beat valid
//   ready_o          stage can accept a beat this cycle
//   flush_i          synchronous flush; drops all held beats and the one
//                    being accepted, emits NOP/0 with valid_o=0
//   inst_o           instruction to decode (oldest held beat, NOP when empty)
//   inst_addr_o      address to decode (0 when empty)
//   valid_o          inst_o/inst_addr_o hold a valid beat
//   ready_i          decode accepts the beat this cycle
//   count_o          occupancy, 0..2
module if_id_skid #(
    parameter int unsigned      INST_W   = 32,
    parameter int unsigned      ADDR_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013,
    parameter bit               SKID_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [1:0]        count_o
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [INST_W-1:0] skid_inst;
    logic [ADDR_W-1:0] skid_addr;
    logic              accept;
    logic              consume;

    assign valid_o = (state != EMPTY);
    assign count_o = state;

    // With the skid buffer, ready_o comes from registered state only so no
    // combinational path runs from ready_i back to fetch.
    always_comb begin
        if (SKID_EN) begin
            ready_o = (state != FULL);
        end else begin
            ready_o = ~valid_o | ready_i;
        end
    end

    assign accept  = valid_i & ready_o;
    assign consume = valid_o & ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            inst_o      <= NOP_INST;
            inst_addr_o <= '0;
            skid_inst   <= '0;
            skid_addr   <= '0;
        end else if (flush_i) begin
            // A beat consumed this cycle was already sampled by decode; the
            // beat being accepted and any skid contents are discarded.
            state       <= EMPTY;
            inst_o      <= NOP_INST;
            inst_addr_o <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= ONE;
                        inst_o      <= inst_i;
                        inst_addr_o <= inst_addr_i;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        inst_o      <= inst_i;
                        inst_addr_o <= inst_addr_i;
                    end else if (accept) begin
                        // Only reachable with the skid buffer enabled.
                        if (SKID_EN) begin
                            state     <= FULL;
                            skid_inst <= inst_i;
                            skid_addr <= inst_addr_i;
                        end
                    end else if (consume) begin
                        state       <= EMPTY;
                        inst_o      <= NOP_INST;
                        inst_addr_o <= '0;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state       <= ONE;
                        inst_o      <= skid_inst;
                        inst_addr_o <= skid_addr;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    inst_o      <= NOP_INST;
                    inst_addr_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid: one instance with the skid buffer, one
// single-entry instance, sharing clock, reset and input stimulus.
module tb_if_id_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        valid_i;
    logic        flush_i;
    logic        ready_i;

    logic        ready_o_s,  valid_o_s;
    logic [31:0] inst_o_s,   inst_addr_o_s;
    logic [1:0]  count_o_s;

    logic        ready_o_n,  valid_o_n;
    logic [31:0] inst_o_n,   inst_addr_o_n;
    logic [1:0]  count_o_n;

    int n_cmp;
    int n_err;

    if_id_skid #(.INST_W(32), .ADDR_W(32), .NOP_INST(NOP), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .valid_i(valid_i),
        .ready_o(ready_o_s), .flush_i(flush_i),
        .inst_o(inst_o_s), .inst_addr_o(inst_addr_o_s), .valid_o(valid_o_s),
        .ready_i(ready_i), .count_o(count_o_s)
    );

    if_id_skid #(.INST_W(32), .ADDR_W(32), .NOP_INST(NOP), .SKID_EN(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .valid_i(valid_i),
        .ready_o(ready_o_n), .flush_i(flush_i),
        .inst_o(inst_o_n), .inst_addr_o(inst_addr_o_n), .valid_o(valid_o_n),
        .ready_i(ready_i), .count_o(count_o_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a);
        valid_i     = v;
        inst_addr_i = a;
        inst_i      = 32'hA000_0000 | a;
    endtask

    task automatic chk_s(input string tag, input logic v, input logic [31:0] a,
                         input logic [1:0] c, input logic r);
        chk({tag, ".valid"}, {31'd0, valid_o_s}, {31'd0, v});
        chk({tag, ".addr"},  inst_addr_o_s, a);
        chk({tag, ".inst"},  inst_o_s, v ? (32'hA000_0000 | a) : NOP);
        chk({tag, ".count"}, {30'd0, count_o_s}, {30'd0, c});
        chk({tag, ".ready"}, {31'd0, ready_o_s}, {31'd0, r});
    endtask

    task automatic chk_n(input string tag, input logic v, input logic [31:0] a,
                         input logic [1:0] c);
        chk({tag, ".valid"}, {31'd0, valid_o_n}, {31'd0, v});
        chk({tag, ".addr"},  inst_addr_o_n, a);
        chk({tag, ".inst"},  inst_o_n, v ? (32'hA000_0000 | a) : NOP);
        chk({tag, ".count"}, {30'd0, count_o_n}, {30'd0, c});
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        drive(1'b0, 32'h0);

        // Reset values
        step();
        step();
        chk_s("rst", 1'b0, 32'h0, 2'd0, 1'b1);
        chk_n("rst_ns", 1'b0, 32'h0, 2'd0);
        rst_n = 1'b1;
        step();

        // Streaming at full throughput
        ready_i = 1'b1;
        drive(1'b1, 32'h00); step(); chk_s("str0", 1'b1, 32'h00, 2'd1, 1'b1);
        drive(1'b1, 32'h04); step(); chk_s("str1", 1'b1, 32'h04, 2'd1, 1'b1);
        drive(1'b1, 32'h08); step(); chk_s("str2", 1'b1, 32'h08, 2'd1, 1'b1);
        drive(1'b1, 32'h0C); step(); chk_s("str3", 1'b1, 32'h0C, 2'd1, 1'b1);
        drive(1'b0, 32'h0);  step(); chk_s("str_drain", 1'b0, 32'h0, 2'd0, 1'b1);

        // Skid fill and ordered drain
        ready_i = 1'b0;
        drive(1'b1, 32'h100); step(); chk_s("skid1", 1'b1, 32'h100, 2'd1, 1'b1);
        drive(1'b1, 32'h104); step(); chk_s("skid2", 1'b1, 32'h100, 2'd2, 1'b0);
        drive(1'b0, 32'h0);   step(); chk_s("skid_hold", 1'b1, 32'h100, 2'd2, 1'b0);
        ready_i = 1'b1;
        #1 chk_s("skid_pre", 1'b1, 32'h100, 2'd2, 1'b0);
        step(); chk_s("skid_out1", 1'b1, 32'h104, 2'd1, 1'b1);
        step(); chk_s("skid_out2", 1'b0, 32'h0, 2'd0, 1'b1);

        // Flush while FULL; neither beat may appear afterwards
        ready_i = 1'b0;
        drive(1'b1, 32'h200); step();
        drive(1'b1, 32'h204); step(); chk_s("fl_full", 1'b1, 32'h200, 2'd2, 1'b0);
        drive(1'b0, 32'h0);
        flush_i = 1'b1;
        step(); chk_s("fl_after", 1'b0, 32'h0, 2'd0, 1'b1);
        flush_i = 1'b0;
        ready_i = 1'b1;
        step(); chk_s("fl_gone1", 1'b0, 32'h0, 2'd0, 1'b1);
        step(); chk_s("fl_gone2", 1'b0, 32'h0, 2'd0, 1'b1);

        // Flush + accept + consume in one cycle
        drive(1'b1, 32'h300); step(); chk_s("fac_one", 1'b1, 32'h300, 2'd1, 1'b1);
        drive(1'b1, 32'h304);
        flush_i = 1'b1;
        #1 chk_s("fac_deliver", 1'b1, 32'h300, 2'd1, 1'b1);
        step(); chk_s("fac_after", 1'b0, 32'h0, 2'd0, 1'b1);
        flush_i = 1'b0;
        drive(1'b0, 32'h0);
        step(); chk_s("fac_drop", 1'b0, 32'h0, 2'd0, 1'b1);

        // Asynchronous reset while FULL, mid-cycle
        ready_i = 1'b0;
        drive(1'b1, 32'h400); step();
        drive(1'b1, 32'h404); step(); chk_s("ar_full", 1'b1, 32'h400, 2'd2, 1'b0);
        drive(1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1 chk_s("ar_now", 1'b0, 32'h0, 2'd0, 1'b1);
        step();
        rst_n = 1'b1;
        step();

        // Single-entry instance: ready_o = ~valid_o | ready_i
        ready_i = 1'b1;
        drive(1'b1, 32'h500);
        #1 chk("ns_rdyA", {31'd0, ready_o_n}, 32'd1);
        step(); chk_n("ns_A", 1'b1, 32'h500, 2'd1);
        ready_i = 1'b0;
        drive(1'b1, 32'h504);
        #1 chk("ns_rdyB", {31'd0, ready_o_n}, 32'd0);
        step(); chk_n("ns_B", 1'b1, 32'h500, 2'd1);
        ready_i = 1'b1;
        #1 chk("ns_rdyC", {31'd0, ready_o_n}, 32'd1);
        step(); chk_n("ns_C", 1'b1, 32'h504, 2'd1);
        ready_i = 1'b0;
        drive(1'b1, 32'h508);
        #1 chk("ns_rdyD", {31'd0, ready_o_n}, 32'd0);
        step(); chk_n("ns_D", 1'b1, 32'h504, 2'd1);
        ready_i = 1'b1;
        #1 chk("ns_rdyE", {31'd0, ready_o_n}, 32'd1);
        step(); chk_n("ns_E", 1'b1, 32'h508, 2'd1);
        drive(1'b0, 32'h0);
        step(); chk_n("ns_drain", 1'b0, 32'h0, 2'd0);
        chk("ns_rdy_empty", {31'd0, ready_o_n}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
